// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the two-channel FFT frame arbiter.
package fft_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FFT_POINT  = 256;
  localparam int unsigned USEDW_W    = 10;
  localparam int unsigned RST_CYCLES = 10;
  localparam int unsigned CNT_W      = $clog2(FFT_POINT);

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_RDY,
    IDLE,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry output FIFO between the sample FIFOs and the FFT core; count feeds the read credit.
module fft_skid_buf #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fft_frame_arbiter.sv
// Shares one streaming FFT core between two sample FIFOs: sequences core reset,
// grants whole frames round-robin and streams them with sop/eop framing.
module fft_frame_arbiter
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W     = fft_pkg::DATA_W,
  parameter int unsigned FFT_POINT  = fft_pkg::FFT_POINT,
  parameter int unsigned USEDW_W    = fft_pkg::USEDW_W,
  parameter int unsigned RST_CYCLES = fft_pkg::RST_CYCLES
) (
  input  logic               clk_50m,
  input  logic               rst_n,
  input  logic               run,
  input  logic [USEDW_W-1:0] ch0_usedw,
  input  logic [USEDW_W-1:0] ch1_usedw,
  input  logic               ch0_empty,
  input  logic               ch1_empty,
  input  logic [DATA_W-1:0]  ch0_q,
  input  logic [DATA_W-1:0]  ch1_q,
  output logic               ch0_rdreq,
  output logic               ch1_rdreq,
  input  logic               fft_ready,
  output logic               fft_rst_n,
  output logic               fft_valid,
  output logic               fft_sop,
  output logic               fft_eop,
  output logic [DATA_W-1:0]  fft_data,
  output logic               fft_chan,
  output logic               frame_done,
  output logic               underrun_err
);

  localparam int unsigned CW   = $clog2(FFT_POINT);
  localparam int unsigned RL_W = CW + 1;
  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

  state_t            state;
  logic [RC_W-1:0]   rst_cnt;
  logic [RL_W-1:0]   reads_left;
  logic              in_flight;
  logic              last_served;
  logic [CW-1:0]     out_cnt;
  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_head;

  logic              elig0_c;
  logic              elig1_c;
  logic              pick_c;
  logic              pop_c;
  logic              sel_empty_c;
  logic [2:0]        credit_c;
  logic              rd_c;
  logic [DATA_W-1:0] wr_data_c;

  assign elig0_c = 32'(ch0_usedw) >= FFT_POINT;
  assign elig1_c = 32'(ch1_usedw) >= FFT_POINT;
  // On a tie the channel not served last wins; otherwise whichever is eligible.
  assign pick_c  = (elig0_c && elig1_c) ? ~last_served : elig1_c;

  assign fft_valid = (buf_count != 2'd0);
  assign fft_data  = buf_head;
  assign fft_sop   = fft_valid && (out_cnt == '0);
  assign fft_eop   = fft_valid && (out_cnt == CW'(FFT_POINT - 1));
  assign pop_c     = fft_valid && fft_ready;

  // A read is issued only if its sample is sure to find a free buffer slot.
  assign sel_empty_c = fft_chan ? ch1_empty : ch0_empty;
  assign credit_c    = 3'(buf_count) + 3'(in_flight) + 3'd1 - 3'(pop_c);
  assign rd_c        = (state == STREAM) && (reads_left != '0) &&
                       (credit_c <= 3'd2) && !sel_empty_c;
  assign ch0_rdreq   = rd_c && !fft_chan;
  assign ch1_rdreq   = rd_c && fft_chan;
  assign wr_data_c   = fft_chan ? ch1_q : ch0_q;

  fft_skid_buf #(
    .W(DATA_W)
  ) u_buf (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .push  (in_flight),
    .din   (wr_data_c),
    .pop   (pop_c),
    .head  (buf_head),
    .count (buf_count)
  );

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_HOLD;
      rst_cnt      <= '0;
      fft_rst_n    <= 1'b0;
      last_served  <= 1'b1;
      fft_chan     <= 1'b0;
      reads_left   <= '0;
      in_flight    <= 1'b0;
      out_cnt      <= '0;
      frame_done   <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      in_flight  <= rd_c;
      if (pop_c) begin
        out_cnt <= out_cnt + CW'(1);
      end
      case (state)
        RST_HOLD: begin
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            fft_rst_n <= 1'b1;
            state     <= WAIT_RDY;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        WAIT_RDY: begin
          if (fft_ready) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (run && (elig0_c || elig1_c)) begin
            fft_chan    <= pick_c;
            last_served <= pick_c;
            reads_left  <= RL_W'(FFT_POINT);
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (sel_empty_c && (reads_left != '0)) begin
            underrun_err <= 1'b1;
          end
          if (rd_c) begin
            reads_left <= reads_left - RL_W'(1);
            if (reads_left == RL_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop_c && fft_eop) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Scoreboard bench: expected samples are queued per frame, a negedge monitor checks each accepted sample.
module tb_fft_frame_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned NP = 256;
  localparam int unsigned UW = 10;
  localparam int unsigned RC = 10;

  typedef struct packed {
    logic          chan;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } smp_t;

  logic          clk_50m = 1'b0;
  logic          rst_n;
  logic          run;
  logic [UW-1:0] ch0_usedw, ch1_usedw;
  logic          ch0_empty, ch1_empty;
  logic [DW-1:0] ch0_q, ch1_q;
  logic          ch0_rdreq, ch1_rdreq;
  logic          fft_ready;
  logic          fft_rst_n, fft_valid, fft_sop, fft_eop;
  logic [DW-1:0] fft_data;
  logic          fft_chan, frame_done, underrun_err;

  int   pushed[2]  = '{0, 0};
  int   popped[2]  = '{0, 0};
  int   exp_idx[2] = '{0, 0};
  logic force_empty1 = 1'b0;
  logic bp_en = 1'b0;

  smp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  int   acc_in_frame = 0;

  always #5 clk_50m = ~clk_50m;

  fft_frame_arbiter u_dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .run          (run),
    .ch0_usedw    (ch0_usedw),
    .ch1_usedw    (ch1_usedw),
    .ch0_empty    (ch0_empty),
    .ch1_empty    (ch1_empty),
    .ch0_q        (ch0_q),
    .ch1_q        (ch1_q),
    .ch0_rdreq    (ch0_rdreq),
    .ch1_rdreq    (ch1_rdreq),
    .fft_ready    (fft_ready),
    .fft_rst_n    (fft_rst_n),
    .fft_valid    (fft_valid),
    .fft_sop      (fft_sop),
    .fft_eop      (fft_eop),
    .fft_data     (fft_data),
    .fft_chan     (fft_chan),
    .frame_done   (frame_done),
    .underrun_err (underrun_err)
  );

  function automatic logic [DW-1:0] ramp(input int ch, input int idx);
    return DW'((ch << 15) | (idx & 32'h7fff));
  endfunction

  // Sample FIFO models: fill level is pushed minus popped, data is a per-channel ramp.
  assign ch0_usedw = UW'(pushed[0] - popped[0]);
  assign ch1_usedw = UW'(pushed[1] - popped[1]);
  assign ch0_empty = (pushed[0] == popped[0]);
  assign ch1_empty = (pushed[1] == popped[1]) || force_empty1;

  always @(posedge clk_50m) begin
    if (ch0_rdreq) begin
      ch0_q     <= ramp(0, popped[0]);
      popped[0] <= popped[0] + 1;
    end
    if (ch1_rdreq) begin
      ch1_q     <= ramp(1, popped[1]);
      popped[1] <= popped[1] + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted sample with the scoreboard head and tracks frame_done.
  initial begin
    logic exp_done;
    int   issued;
    int   accepted;
    smp_t act;
    smp_t e;
    exp_done = 1'b0;
    issued   = 0;
    accepted = 0;
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        exp_done     = 1'b0;
        acc_in_frame = 0;
        issued       = 0;
        accepted     = 0;
        continue;
      end
      if (exp_done || frame_done) chk("frame_done", 64'(frame_done), 64'(exp_done));
      if (frame_done) frames_done++;
      exp_done = 1'b0;
      if (force_empty1) chk("rdreq_hold", 64'(ch1_rdreq), 64'(0));
      if (ch0_rdreq || ch1_rdreq) issued++;
      if (fft_valid && fft_ready) begin
        accepted++;
        act = {fft_chan, fft_sop, fft_eop, fft_data};
        chk("sample_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sample", 64'(act), 64'(e));
        end
        if (fft_eop) begin
          acc_in_frame = 0;
          exp_done     = 1'b1;
        end else begin
          acc_in_frame++;
        end
      end
      chk("occupancy", 64'((issued - accepted) <= 2), 64'(1));
    end
  end

  task automatic step();
    @(posedge clk_50m);
    #1;
    if (bp_en) fft_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_frame(input int ch);
    smp_t s;
    for (int i = 0; i < int'(NP); i++) begin
      s.chan = 1'(ch);
      s.sop  = (i == 0);
      s.eop  = (i == int'(NP) - 1);
      s.data = ramp(ch, exp_idx[ch]);
      exp_idx[ch]++;
      exp_q.push_back(s);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frames_done < n && t < budget) begin
      step();
      t++;
    end
    chk("frames_done", 64'(frames_done), 64'(n));
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    repeat (2) step();
    chk("reset_outputs",
        64'({ch0_rdreq, ch1_rdreq, fft_rst_n, fft_valid, fft_sop, fft_eop,
             fft_data, fft_chan, frame_done, underrun_err}), 64'(0));
    rst_n = 1'b1;
    for (int k = 1; k <= int'(RC); k++) begin
      step();
      chk("fft_rst_n", 64'(fft_rst_n), 64'(k == int'(RC)));
      chk("early_rdreq", 64'(ch0_rdreq | ch1_rdreq), 64'(0));
    end
  endtask

  initial begin
    int base;
    int t;
    rst_n     = 1'b0;
    run       = 1'b1;
    fft_ready = 1'b1;

    // Single channel: one ch0 frame straight after the core reset sequence.
    pushed[0] += 256;
    push_frame(0);
    reset_seq();
    wait_frames(1, 1000);
    repeat (5) step();
    chk("ch0_reads", 64'(popped[0]), 64'(256));

    // Round-robin: last served was ch0, so ties go 1,0,1,0.
    pushed[0] += 512;
    pushed[1] += 512;
    push_frame(1);
    push_frame(0);
    push_frame(1);
    push_frame(0);
    wait_frames(5, 2000);

    // Random backpressure on a ch1 frame.
    bp_en = 1'b1;
    pushed[1] += 256;
    push_frame(1);
    wait_frames(6, 3000);
    bp_en     = 1'b0;
    fft_ready = 1'b1;

    // Underrun: ch1 looks empty for 5 cycles mid-frame.
    chk("underrun_clear", 64'(underrun_err), 64'(0));
    pushed[1] += 256;
    push_frame(1);
    base = popped[1];
    t = 0;
    while (popped[1] - base < 100 && t < 1000) begin
      step();
      t++;
    end
    force_empty1 = 1'b1;
    repeat (5) step();
    force_empty1 = 1'b0;
    chk("underrun_set", 64'(underrun_err), 64'(1));
    wait_frames(7, 1000);
    repeat (3) step();
    chk("underrun_sticky", 64'(underrun_err), 64'(1));

    // Abort: reset mid-frame at sample 100, then a full frame after the rerun sequence.
    pushed[0] += 256;
    push_frame(0);
    t = 0;
    while (acc_in_frame != 100 && t < 1000) begin
      step();
      t++;
    end
    chk("abort_point", 64'(acc_in_frame), 64'(100));
    rst_n = 1'b0;
    exp_q.delete();
    exp_idx[0] = popped[0];
    pushed[0] += 256;
    push_frame(0);
    fft_ready = 1'b0;
    reset_seq();
    repeat (3) step();
    chk("wait_rdy_hold", 64'({ch0_rdreq, ch1_rdreq, fft_valid}), 64'(0));
    fft_ready = 1'b1;
    wait_frames(8, 1000);

    repeat (5) step();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
